loop_control: RTL and testbench

LOOP_CONTROL -- requirements
Module: loop_control

---
 rtl/loop_control_if.sv | 30 +++
 rtl/loop_control.sv | 151 +++++++++++++++
 tb/tb_loop_control.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_control_if.sv
// Handshake and bus signals between the loop controller and its environment.
interface loop_control_if;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 8;

    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               cell_zero;
    logic               exec_ready;
    logic [ADDR_W-1:0]  stack_top;
    logic [ADDR_W-1:0]  pc;
    logic               exec_valid;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  push_addr;
    logic               halted;
    logic               error;

    // Controller side
    modport master (
        input  start, instr, cell_zero, exec_ready, stack_top,
        output pc, exec_valid, push, pop, push_addr, halted, error
    );

    // Program memory / datapath / loop stack side
    modport slave (
        output start, instr, cell_zero, exec_ready, stack_top,
        input  pc, exec_valid, push, pop, push_addr, halted, error
    );
endinterface

// File: rtl/loop_control.sv
// Bracket-loop sequencer: walks program memory, dispatches datapath opcodes,
// drives an external loop stack and skips loop bodies whose cell is zero.
module loop_control (
    input  logic           clk,
    input  logic           reset,
    loop_control_if.master bus
);
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DEPTH_W   = 6;
    localparam int unsigned NEST_W    = 10;
    localparam int unsigned MAX_DEPTH = 32;

    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;
    localparam logic [7:0] OP_END   = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SKIP,
        HALT,
        ERROR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [DEPTH_W-1:0]  depth;
    logic [NEST_W-1:0]   nest;

    logic is_open;
    logic is_close;
    logic is_end;
    logic is_dp;
    logic pc_last;
    logic depth_full;
    logic depth_empty;

    // Opcode classification of the byte currently at pc
    always_comb begin
        is_open     = (bus.instr == OP_OPEN);
        is_close    = (bus.instr == OP_CLOSE);
        is_end      = (bus.instr == OP_END);
        is_dp       = (bus.instr == 8'h2B) || (bus.instr == 8'h2D) ||
                      (bus.instr == 8'h3C) || (bus.instr == 8'h3E) ||
                      (bus.instr == 8'h2E) || (bus.instr == 8'h2C);
        pc_last     = (pc == {ADDR_W{1'b1}});
        depth_full  = (depth == DEPTH_W'(MAX_DEPTH));
        depth_empty = (depth == '0);
    end

    // Strobes decoded from state and current opcode; only RUN can raise them
    always_comb begin
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.exec_valid = 1'b0;
        if (state == RUN) begin
            bus.push       = is_open && !bus.cell_zero && !depth_full;
            bus.pop        = is_close && bus.cell_zero && !depth_empty;
            bus.exec_valid = is_dp;
        end
    end

    assign bus.pc        = pc;
    assign bus.push_addr = pc;
    assign bus.halted    = (state == HALT);
    assign bus.error     = (state == ERROR);

    // Sequencer state, program counter, stack depth and skip nesting
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            depth <= '0;
            nest  <= '0;
        end else begin
            case (state)
                IDLE, HALT, ERROR: begin
                    if (bus.start) begin
                        state <= RUN;
                        pc    <= '0;
                        depth <= '0;
                        nest  <= '0;
                    end
                end

                RUN: begin
                    if (is_end) begin
                        state <= HALT;
                    end else if (is_open) begin
                        if (bus.cell_zero) begin
                            // An opening bracket in the last slot can never be matched
                            if (pc_last) begin
                                state <= ERROR;
                            end else begin
                                state <= SKIP;
                                nest  <= NEST_W'(1);
                                pc    <= pc + ADDR_W'(1);
                            end
                        end else if (depth_full) begin
                            state <= ERROR;
                        end else begin
                            depth <= depth + DEPTH_W'(1);
                            if (pc_last) state <= HALT;
                            else         pc    <= pc + ADDR_W'(1);
                        end
                    end else if (is_close) begin
                        if (depth_empty) begin
                            state <= ERROR;
                        end else if (!bus.cell_zero) begin
                            // Loop back to the body start, keeping the stack entry
                            pc <= bus.stack_top + ADDR_W'(1);
                        end else begin
                            depth <= depth - DEPTH_W'(1);
                            if (pc_last) state <= HALT;
                            else         pc    <= pc + ADDR_W'(1);
                        end
                    end else if (is_dp) begin
                        if (bus.exec_ready) begin
                            if (pc_last) state <= HALT;
                            else         pc    <= pc + ADDR_W'(1);
                        end
                    end else begin
                        if (pc_last) state <= HALT;
                        else         pc    <= pc + ADDR_W'(1);
                    end
                end

                SKIP: begin
                    if (is_end) begin
                        state <= ERROR;
                    end else if (is_close && nest == NEST_W'(1)) begin
                        nest <= '0;
                        if (pc_last) begin
                            state <= HALT;
                        end else begin
                            state <= RUN;
                            pc    <= pc + ADDR_W'(1);
                        end
                    end else begin
                        if (is_open)       nest <= nest + NEST_W'(1);
                        else if (is_close) nest <= nest - NEST_W'(1);
                        if (pc_last) state <= ERROR;
                        else         pc    <= pc + ADDR_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_loop_control.sv
// Directed bench for loop_control with a loop-stack model and strobe scoreboard.
module tb_loop_control;
    logic clk = 1'b0;
    logic reset;

    loop_control_if bus ();

    loop_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [1024];
    logic       cz  [1024];
    logic [9:0] stk [64];
    logic [5:0] sp;

    logic [9:0] exp_push [$];
    logic [9:0] exp_pop  [$];

    int total = 0;
    int bad   = 0;
    int exec_cnt = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;

    assign bus.instr     = mem[bus.pc];
    assign bus.cell_zero = cz[bus.pc];
    assign bus.stack_top = (sp != 6'd0) ? stk[sp - 6'd1] : 10'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score strobes of the current cycle, update the stack model, advance one clock
    task automatic step();
        chk("push_pop_excl", 32'(bus.push & bus.pop), 32'd0);
        if (bus.exec_valid === 1'b1) exec_cnt++;
        if (bus.push === 1'b1) begin
            push_cnt++;
            chk("push_expected", 32'(exp_push.size() != 0), 32'd1);
            if (exp_push.size() != 0) chk("push_addr", 32'(bus.push_addr), 32'(exp_push.pop_front()));
            stk[sp] = bus.push_addr;
            sp = sp + 6'd1;
        end
        if (bus.pop === 1'b1) begin
            pop_cnt++;
            chk("pop_expected", 32'(exp_pop.size() != 0), 32'd1);
            if (exp_pop.size() != 0) chk("pop_pc", 32'(bus.pc), 32'(exp_pop.pop_front()));
            sp = sp - 6'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h00;
            cz[i]  = 1'b0;
        end
        for (int i = 0; i < s.len(); i++) mem[10'(i)] = s[i];
    endtask

    task automatic set_cz(input logic v);
        for (int i = 0; i < 1024; i++) cz[i] = v;
    endtask

    task automatic go();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_until(input int max, input string tag);
        int n = 0;
        while (!(bus.halted || bus.error) && n < max) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(bus.halted | bus.error), 32'd1);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_push_left"}, 32'(exp_push.size()), 32'd0);
        chk({tag, "_pop_left"},  32'(exp_pop.size()),  32'd0);
    endtask

    int e0;
    int p0;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.exec_ready = 1'b1;
        sp = 6'd0;
        load("");
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        sp = 6'd0;

        // Reset state
        chk("rst_pc",     32'(bus.pc), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_error",  32'(bus.error), 32'd0);
        chk("rst_exec",   32'(bus.exec_valid), 32'd0);

        // Zero cell skips the whole loop body
        load("[+]");
        set_cz(1'b1);
        e0 = exec_cnt; p0 = push_cnt;
        go();
        chk("skip_pc0", 32'(bus.pc), 32'd0);
        step();
        chk("skip_pc1", 32'(bus.pc), 32'd1);
        chk("skip_no_exec", 32'(bus.exec_valid), 32'd0);
        step();
        chk("skip_pc2", 32'(bus.pc), 32'd2);
        step();
        chk("skip_pc3", 32'(bus.pc), 32'd3);
        chk("skip_run_not_halted", 32'(bus.halted), 32'd0);
        step();
        chk("skip_halted", 32'(bus.halted), 32'd1);
        chk("skip_halt_pc", 32'(bus.pc), 32'd3);
        chk("skip_exec_cnt", 32'(exec_cnt - e0), 32'd0);
        chk("skip_push_cnt", 32'(push_cnt - p0), 32'd0);

        // Nested loops entered once and exited through pops
        load("[[]]");
        cz[2] = 1'b1;
        cz[3] = 1'b1;
        exp_push.push_back(10'd0);
        exp_push.push_back(10'd1);
        exp_pop.push_back(10'd2);
        exp_pop.push_back(10'd3);
        go();
        run_until(20, "nest");
        chk("nest_halted", 32'(bus.halted), 32'd1);
        chk("nest_pc", 32'(bus.pc), 32'd4);
        chk("nest_depth", 32'(sp), 32'd0);
        drained("nest");

        // Loop back through stack_top while the cell is nonzero
        load("[+]");
        exp_push.push_back(10'd0);
        go();
        step();
        step();
        chk("loop_pc2", 32'(bus.pc), 32'd2);
        step();
        chk("loop_jump_pc", 32'(bus.pc), 32'd1);
        chk("loop_depth_kept", 32'(sp), 32'd1);
        cz[2] = 1'b1;
        exp_pop.push_back(10'd2);
        step();
        step();
        chk("loop_exit_pc", 32'(bus.pc), 32'd3);
        step();
        chk("loop_halted", 32'(bus.halted), 32'd1);
        chk("loop_depth", 32'(sp), 32'd0);
        drained("loop");

        // Stack overflow on the 33rd nested bracket
        load("");
        for (int i = 0; i < 33; i++) mem[10'(i)] = 8'h5B;
        for (int i = 0; i < 32; i++) exp_push.push_back(10'(i));
        p0 = push_cnt;
        go();
        run_until(60, "ovf");
        chk("ovf_error", 32'(bus.error), 32'd1);
        chk("ovf_pc", 32'(bus.pc), 32'd32);
        step();
        step();
        chk("ovf_push_cnt", 32'(push_cnt - p0), 32'd32);
        chk("ovf_pc_hold", 32'(bus.pc), 32'd32);
        drained("ovf");

        // Unmatched closing bracket
        load("]");
        sp = 6'd0;
        p0 = pop_cnt;
        go();
        step();
        chk("close_error", 32'(bus.error), 32'd1);
        chk("close_pc", 32'(bus.pc), 32'd0);
        chk("close_no_pop", 32'(pop_cnt - p0), 32'd0);

        // Datapath stall with start ignored mid-run
        load("     +");
        bus.exec_ready = 1'b0;
        go();
        for (int i = 0; i < 5; i++) step();
        chk("stall_pc", 32'(bus.pc), 32'd5);
        e0 = exec_cnt;
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(bus.exec_valid), 32'd1);
            chk("stall_pc_hold", 32'(bus.pc), 32'd5);
            bus.start = (k == 1);
            step();
            bus.start = 1'b0;
        end
        bus.exec_ready = 1'b1;
        chk("accept_valid", 32'(bus.exec_valid), 32'd1);
        chk("accept_pc", 32'(bus.pc), 32'd5);
        step();
        chk("after_accept_pc", 32'(bus.pc), 32'd6);
        chk("stall_exec_cycles", 32'(exec_cnt - e0), 32'd4);
        step();
        chk("stall_halted", 32'(bus.halted), 32'd1);

        // Reset in the middle of a nested skip
        load("[[ab]]");
        set_cz(1'b1);
        go();
        step();
        step();
        chk("skip2_pc", 32'(bus.pc), 32'd2);
        reset = 1'b1;
        bus.start = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        sp = 6'd0;
        chk("mid_rst_pc", 32'(bus.pc), 32'd0);
        chk("mid_rst_push", 32'(bus.push), 32'd0);
        chk("mid_rst_pop", 32'(bus.pop), 32'd0);
        chk("mid_rst_exec", 32'(bus.exec_valid), 32'd0);
        chk("mid_rst_halted", 32'(bus.halted), 32'd0);
        chk("mid_rst_error", 32'(bus.error), 32'd0);
        load("+");
        go();
        chk("resume_pc", 32'(bus.pc), 32'd0);
        chk("resume_exec", 32'(bus.exec_valid), 32'd1);
        step();
        chk("resume_pc1", 32'(bus.pc), 32'd1);
        step();
        chk("resume_halted", 32'(bus.halted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
